me_search_ctrl: RTL and testbench
=================================

# me_search_ctrl

Parametrised full-search sequencer for the block-matching motion estimator. It drives the reference-block memory, the two search-window memories and the PE array with one-hot accumulation-start strobes, PE ready strobes, S1/S2 select lines and candidate motion vectors. Block size, PE count and vertical search range are generic. Compared with the fixed 16×16 controller, it adds a start/busy/done handshake, stall and abort inputs, and an asynchronous reset.

## Interface
- N, 16: block size and PE count; power of 2, at least 4. L = log2(N).
- NV, 16: vertical candidate positions; power of 2, at least 2. LV = log2(NV).
- Derived constants:
  - LAST = NV·N·N + N − 1; default 4111.
  - CW = clog2(LAST+1); default 13.
  - SW = clog2(2N·(NV+N)); default 10.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  run request, sampled only in IDLE
- stall  in  1  freeze the sequence for this cycle
- abort  in  1  cancel the run, synchronous
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after a normal completion
- count  out  CW  sequence counter
- new_dist  out  N  one-hot accumulation-start strobe, one bit per PE
- pe_ready  out  N  PE result-valid strobe
- s1s2_mux  out  N  per-PE select: 1 = S1, 0 = S2
- comp_start  out  1  comparator enable
- addr_r  out  2L  reference-memory address
- addr_s1  out  SW  search-memory S1 address
- addr_s2  out  SW  search-memory S2 address
- vector_x  out  L  candidate horizontal offset, two's complement
- vector_y  out  LV  candidate vertical offset, two's complement

## Operation

Counter fields, taken from count:
- col = count[L−1:0]
- row = count[2L−1:L]
- vpos = count[2L+LV−1:2L]

FSM states are IDLE, RUN and a transient DONE. DONE is not a held state; it exists only as the done pulse.

State transitions:
- IDLE:
  - start=1 and abort=0 → RUN, count←0.
  - Otherwise count holds its value.
- RUN:
  - abort=1 → IDLE, count←0, no done pulse. Abort has priority over stall.
  - stall=1 → all registers hold.
  - count==LAST → IDLE, done←1 for one cycle, count holds LAST.
  - Otherwise count←count+1.
- start while in RUN is ignored.

Decode is combinational from the registered count. All arithmetic wraps modulo the output width.
- new_dist[i] = busy & ~stall & (count[2L−1:0]==i)
- comp_start = busy & (count ≥ N·N)
- pe_ready[i] = new_dist[i] & comp_start
- s1s2_mux[i] = (col ≥ i). This output is not gated by busy.
- addr_r = {row, col}
- addr_s1 = (vpos+row)·2N + col
- addr_s2 is decoded from t = count − N, truncated to 2L+LV bits: addr_s2 = (t.vpos + t.row)·2N + t.col + N
- vector_x = col − N/2
- vector_y = vpos − NV/2 − 1

## Timing
- Reset values:
  - FSM state = IDLE; count, busy and done = 0.
  - The decoded outputs then follow from count=0 with busy=0: addr_* as decoded, s1s2_mux[0]=1, strobes all 0.
- Latency:
  - start sampled high at edge k → busy=1 and count=0 from edge k.
  - An unstalled run occupies exactly LAST+1 busy cycles; default 4112.
  - done rises at the edge that leaves count==LAST, together with busy falling.
- Back-to-back: start asserted in the done cycle is accepted; the next run begins with no gap.
- Each stall cycle extends the run by one cycle. Strobes are suppressed during stall, so no PE latches twice.
- Reset mid-run clears state immediately and without a clock; no done pulse is produced.
- Simultaneous events:
  - abort with start in IDLE: stays IDLE.
  - abort at count==LAST: abort wins, so there is no done pulse.

## Structure
- Shared package me_pkg holds:
  - the clog2 function;
  - the state enum (IDLE, RUN);
  - constant functions for LAST, CW and SW.
- One sub-module, me_addr_gen: purely combinational count → addresses/vectors decode, parametrised by N and NV.
- The top level holds the FSM, the counter and the strobe gating.

## Test plan
1. Defaults, single start pulse, no stalls → busy high 4112 cycles, done one pulse, count=4111 afterwards, exactly 16·16 pe_ready pulses in total.
2. Defaults, sample at count=0x123 → addr_r=0x23, addr_s1=99, addr_s2=83, s1s2_mux=0x000F, vector_x=0xB (−5), vector_y=0x8 (−8).
3. Defaults, count=256 → comp_start=1, pe_ready=0x0001; count=255 → pe_ready=0.
4. Stall for 10 cycles at count=300 → count frozen, new_dist=pe_ready=0 during the stall, run length 4122, done still fires.
5. Abort at count=1000 → next cycle busy=0, count=0, no done pulse. A start in the following cycle runs to completion normally.
6. N=8, NV=8 → CW=10, LAST=519, 520 busy cycles. Async reset at count=200 → count=0 and busy=0 before the next clock edge.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants, helper functions and state type for the motion-estimation sequencer.
package me_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Final counter value of a search run.
  function automatic int last_f(input int n, input int nv);
    return nv * n * n + n - 1;
  endfunction

  // Sequence counter width.
  function automatic int cw_f(input int n, input int nv);
    return clog2(last_f(n, nv) + 1);
  endfunction

  // Search-window memory address width.
  function automatic int sw_f(input int n, input int nv);
    return clog2(2 * n * (nv + n));
  endfunction

endpackage

// File: rtl/me_addr_gen.sv
// Combinational decode of the sequence counter into memory addresses,
// S1/S2 select lines and the candidate motion vector.
module me_addr_gen
  import me_pkg::*;
#(
  parameter int N  = 16,
  parameter int NV = 16
) (
  input  logic [cw_f(N, NV)-1:0]    count,
  output logic [N-1:0]              s1s2_mux,
  output logic [2*clog2(N)-1:0]     addr_r,
  output logic [sw_f(N, NV)-1:0]    addr_s1,
  output logic [sw_f(N, NV)-1:0]    addr_s2,
  output logic [clog2(N)-1:0]       vector_x,
  output logic [clog2(NV)-1:0]      vector_y
);

  localparam int L  = clog2(N);
  localparam int LV = clog2(NV);
  localparam int CW = cw_f(N, NV);
  localparam int SW = sw_f(N, NV);
  localparam int TW = 2 * L + LV;

  logic [L-1:0]  col;
  logic [L-1:0]  row;
  logic [LV-1:0] vpos;
  logic [CW-1:0] t_full;
  logic [L-1:0]  t_col;
  logic [L-1:0]  t_row;
  logic [LV-1:0] t_vpos;

  // Split count (and count delayed by N for the S2 stream) into col/row/vpos and decode.
  always_comb begin
    col      = count[L-1:0];
    row      = count[2*L-1:L];
    vpos     = count[TW-1:2*L];
    t_full   = count - CW'(N);
    t_col    = t_full[L-1:0];
    t_row    = t_full[2*L-1:L];
    t_vpos   = t_full[TW-1:2*L];
    addr_r   = {row, col};
    addr_s1  = (SW'(vpos) + SW'(row)) * SW'(2 * N) + SW'(col);
    addr_s2  = (SW'(t_vpos) + SW'(t_row)) * SW'(2 * N) + SW'(t_col) + SW'(N);
    vector_x = col - L'(N / 2);
    vector_y = vpos - LV'(NV / 2) - LV'(1);
    s1s2_mux = '0;
    for (int i = 0; i < N; i++) begin
      s1s2_mux[i] = (col >= L'(i));
    end
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search sequencer: start/busy/done run control with stall and abort,
// a sequence counter, gated PE strobes and the address/vector decode.
//
// Handshake: start is only looked at in IDLE; busy is high for every RUN
// cycle; done pulses for one cycle after a run reaches LAST without abort.
// abort beats stall, stall beats counting. new_dist/pe_ready are suppressed
// in a stalled cycle so each PE sees each strobe exactly once.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int N  = 16,
  parameter int NV = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stall,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [cw_f(N, NV)-1:0]    count,
  output logic [N-1:0]              new_dist,
  output logic [N-1:0]              pe_ready,
  output logic [N-1:0]              s1s2_mux,
  output logic                      comp_start,
  output logic [2*clog2(N)-1:0]     addr_r,
  output logic [sw_f(N, NV)-1:0]    addr_s1,
  output logic [sw_f(N, NV)-1:0]    addr_s2,
  output logic [clog2(N)-1:0]       vector_x,
  output logic [clog2(NV)-1:0]      vector_y
);

  localparam int L    = clog2(N);
  localparam int CW   = cw_f(N, NV);
  localparam int LAST = last_f(N, NV);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // State, counter and done-pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (stall) begin
          state_d = RUN;
        end else if (count_q == CW'(LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Status outputs and strobe gating from the registered count.
  always_comb begin
    busy       = (state_q == RUN);
    done       = done_q;
    count      = count_q;
    comp_start = busy & (count_q >= CW'(N * N));
    new_dist   = '0;
    for (int i = 0; i < N; i++) begin
      new_dist[i] = busy & ~stall & (count_q[2*L-1:0] == (2*L)'(i));
    end
    pe_ready   = new_dist & {N{comp_start}};
  end

  me_addr_gen #(
    .N  (N),
    .NV (NV)
  ) u_addr_gen (
    .count    (count_q),
    .s1s2_mux (s1s2_mux),
    .addr_r   (addr_r),
    .addr_s1  (addr_s1),
    .addr_s2  (addr_s2),
    .vector_x (vector_x),
    .vector_y (vector_y)
  );

endmodule

// File: tb/tb_me_search_ctrl.sv
// Testbench for me_search_ctrl: default (16/16) and small (8/8) instances.
module tb_me_search_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, stall, abort;
  logic reset_b, start_b, stall_b, abort_b;

  // default instance signals
  logic        busy_a, done_a, comp_start_a;
  logic [12:0] count_a;
  logic [15:0] new_dist_a, pe_ready_a, s1s2_mux_a;
  logic [7:0]  addr_r_a;
  logic [9:0]  addr_s1_a, addr_s2_a;
  logic [3:0]  vector_x_a, vector_y_a;

  // N=8, NV=8 instance signals
  logic        busy_b, done_b, comp_start_b;
  logic [9:0]  count_b;
  logic [7:0]  new_dist_b, pe_ready_b, s1s2_mux_b;
  logic [5:0]  addr_r_b;
  logic [7:0]  addr_s1_b, addr_s2_b;
  logic [2:0]  vector_x_b, vector_y_b;

  me_search_ctrl #(.N(16), .NV(16)) dut_a (
    .clock(clock), .reset(reset), .start(start), .stall(stall), .abort(abort),
    .busy(busy_a), .done(done_a), .count(count_a), .new_dist(new_dist_a),
    .pe_ready(pe_ready_a), .s1s2_mux(s1s2_mux_a), .comp_start(comp_start_a),
    .addr_r(addr_r_a), .addr_s1(addr_s1_a), .addr_s2(addr_s2_a),
    .vector_x(vector_x_a), .vector_y(vector_y_a)
  );

  me_search_ctrl #(.N(8), .NV(8)) dut_b (
    .clock(clock), .reset(reset_b), .start(start_b), .stall(stall_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .count(count_b), .new_dist(new_dist_b),
    .pe_ready(pe_ready_b), .s1s2_mux(s1s2_mux_b), .comp_start(comp_start_b),
    .addr_r(addr_r_b), .addr_s1(addr_s1_b), .addr_s2(addr_s2_b),
    .vector_x(vector_x_b), .vector_y(vector_y_b)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Running totals sampled mid-cycle; tests diff snapshots of these.
  int busy_tot_a = 0, done_tot_a = 0, pe_tot_a = 0;
  int busy_tot_b = 0, done_tot_b = 0, pe_tot_b = 0;
  always begin
    @(negedge clock);
    #3;
    busy_tot_a += int'(busy_a);
    done_tot_a += int'(done_a);
    pe_tot_a   += $countones(pe_ready_a);
    busy_tot_b += int'(busy_b);
    done_tot_b += int'(done_b);
    pe_tot_b   += $countones(pe_ready_b);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_count_a(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (!(busy_a && int'(count_a) == target) && n < bound) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL %s timeout waiting for count=%0d, actual count=%0d", name, target, count_a);
    end
  endtask

  task automatic wait_done_a(input int bound, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!done_a && n < bound) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL %s timeout waiting for done, actual busy=%0d", name, busy_a);
    end
  endtask

  task automatic pulse_start_a();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          cnt;
    logic [7:0]  ar;
    logic [9:0]  s1;
    logic [9:0]  s2;
    logic [15:0] mux;
    logic [3:0]  vx;
    logic [3:0]  vy;
    logic        cs;
    logic [15:0] nd;
    logic [15:0] pe;
  } vec_t;

  vec_t tbl[9];

  int sb_busy, sb_done, sb_pe;

  initial begin
    tbl[0] = '{0,    8'h00, 10'd0,   10'd976, 16'h0001, 4'h8, 4'h7, 1'b0, 16'h0001, 16'h0000};
    tbl[1] = '{15,   8'h0F, 10'd15,  10'd991, 16'hFFFF, 4'h7, 4'h7, 1'b0, 16'h8000, 16'h0000};
    tbl[2] = '{255,  8'hFF, 10'd495, 10'd479, 16'hFFFF, 4'h7, 4'h7, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{256,  8'h00, 10'd32,  10'd496, 16'h0001, 4'h8, 4'h8, 1'b1, 16'h0001, 16'h0001};
    tbl[4] = '{261,  8'h05, 10'd37,  10'd501, 16'h003F, 4'hD, 4'h8, 1'b1, 16'h0020, 16'h0020};
    tbl[5] = '{291,  8'h23, 10'd99,  10'd83,  16'h000F, 4'hB, 4'h8, 1'b1, 16'h0000, 16'h0000};
    tbl[6] = '{1000, 8'hE8, 10'd552, 10'd536, 16'h01FF, 4'h0, 4'hA, 1'b1, 16'h0000, 16'h0000};
    tbl[7] = '{4096, 8'h00, 10'd0,   10'd976, 16'h0001, 4'h8, 4'h7, 1'b1, 16'h0001, 16'h0001};
    tbl[8] = '{4111, 8'h0F, 10'd15,  10'd991, 16'hFFFF, 4'h7, 4'h7, 1'b1, 16'h8000, 16'h8000};

    reset = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; stall_b = 1'b0; abort_b = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;

    // Reset state: decode from count=0 with busy low.
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_count", count_a, 0);
    check("rst_new_dist", new_dist_a, 0);
    check("rst_pe_ready", pe_ready_a, 0);
    check("rst_comp_start", comp_start_a, 0);
    check("rst_s1s2_mux", s1s2_mux_a, 16'h0001);
    check("rst_addr_s2", addr_s2_a, 976);
    check("rst_vector_y", vector_y_a, 4'h7);

    // Run 1: unstalled run, decode table walked along the way.
    @(negedge clock);
    sb_busy = busy_tot_a; sb_done = done_tot_a; sb_pe = pe_tot_a;
    pulse_start_a();
    check("r1_busy_after_start", busy_a, 1);
    check("r1_count_after_start", count_a, 0);
    for (int k = 0; k < 9; k++) begin
      wait_count_a(tbl[k].cnt, 5000, "tbl_wait");
      #1;
      check($sformatf("addr_r@%0d", tbl[k].cnt), addr_r_a, tbl[k].ar);
      check($sformatf("addr_s1@%0d", tbl[k].cnt), addr_s1_a, tbl[k].s1);
      check($sformatf("addr_s2@%0d", tbl[k].cnt), addr_s2_a, tbl[k].s2);
      check($sformatf("s1s2_mux@%0d", tbl[k].cnt), s1s2_mux_a, tbl[k].mux);
      check($sformatf("vector_x@%0d", tbl[k].cnt), vector_x_a, tbl[k].vx);
      check($sformatf("vector_y@%0d", tbl[k].cnt), vector_y_a, tbl[k].vy);
      check($sformatf("comp_start@%0d", tbl[k].cnt), comp_start_a, tbl[k].cs);
      check($sformatf("new_dist@%0d", tbl[k].cnt), new_dist_a, tbl[k].nd);
      check($sformatf("pe_ready@%0d", tbl[k].cnt), pe_ready_a, tbl[k].pe);
    end
    wait_done_a(100, "r1_done");
    check("r1_busy_at_done", busy_a, 0);
    check("r1_count_at_done", count_a, 4111);
    // Back-to-back start in the done cycle; outputs stay decoded while idle.
    start = 1'b1;
    #1;
    check("r1_idle_mux_ungated", s1s2_mux_a, 16'hFFFF);
    check("r1_idle_addr_r", addr_r_a, 8'h0F);
    check("r1_idle_new_dist", new_dist_a, 0);
    @(negedge clock);
    check("r1_busy_cycles", busy_tot_a - sb_busy, 4112);
    check("r1_done_pulses", done_tot_a - sb_done, 1);
    check("r1_pe_pulses", pe_tot_a - sb_pe, 256);
    start = 1'b0;
    check("b2b_busy", busy_a, 1);
    check("b2b_count", count_a, 0);
    sb_busy = busy_tot_a; sb_done = done_tot_a; sb_pe = pe_tot_a;

    // Run 2: 10-cycle stall at 300, 1-cycle stall at 512.
    wait_count_a(300, 5000, "r2_wait300");
    stall = 1'b1;
    #1;
    check("stall_new_dist", new_dist_a, 0);
    check("stall_pe_ready", pe_ready_a, 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      check($sformatf("stall_count_%0d", i), count_a, 300);
      if (i < 10) begin
        #1;
        check($sformatf("stall_nd_%0d", i), new_dist_a, 0);
        check($sformatf("stall_pe_%0d", i), pe_ready_a, 0);
      end
    end
    stall = 1'b0;
    wait_count_a(512, 5000, "r2_wait512");
    stall = 1'b1;
    #1;
    check("stall512_new_dist", new_dist_a, 0);
    check("stall512_pe_ready", pe_ready_a, 0);
    check("stall512_comp_start", comp_start_a, 1);
    @(negedge clock);
    stall = 1'b0;
    #1;
    check("stall512_count", count_a, 512);
    check("unstall512_new_dist", new_dist_a, 16'h0001);
    check("unstall512_pe_ready", pe_ready_a, 16'h0001);
    wait_done_a(5000, "r2_done");
    check("r2_count_at_done", count_a, 4111);
    @(negedge clock);
    check("r2_busy_cycles", busy_tot_a - sb_busy, 4123);
    check("r2_done_pulses", done_tot_a - sb_done, 1);
    check("r2_pe_pulses", pe_tot_a - sb_pe, 256);

    // Abort together with start in IDLE: stays idle, count held.
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    check("abort_start_busy", busy_a, 0);
    check("abort_start_count", count_a, 4111);
    abort = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("r3_busy", busy_a, 1);
    sb_done = done_tot_a;

    // Abort at count 1000, restart next cycle, run to completion.
    wait_count_a(1000, 5000, "r3_wait1000");
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_count", count_a, 0);
    check("abort_done", done_a, 0);
    pulse_start_a();
    check("abort_done_pulses", done_tot_a - sb_done, 0);
    check("restart_busy", busy_a, 1);
    check("restart_count", count_a, 0);
    sb_busy = busy_tot_a; sb_done = done_tot_a; sb_pe = pe_tot_a;
    wait_done_a(5000, "r4_done");
    check("r4_count_at_done", count_a, 4111);
    @(negedge clock);
    check("r4_busy_cycles", busy_tot_a - sb_busy, 4112);
    check("r4_done_pulses", done_tot_a - sb_done, 1);
    check("r4_pe_pulses", pe_tot_a - sb_pe, 256);

    // Abort (with stall) exactly at LAST: abort wins, no done.
    pulse_start_a();
    sb_done = done_tot_a;
    wait_count_a(4111, 5000, "r5_wait_last");
    abort = 1'b1; stall = 1'b1;
    @(negedge clock);
    abort = 1'b0; stall = 1'b0;
    check("abort_last_busy", busy_a, 0);
    check("abort_last_count", count_a, 0);
    check("abort_last_done", done_a, 0);
    @(negedge clock);
    check("abort_last_done_next", done_a, 0);
    check("abort_last_done_pulses", done_tot_a - sb_done, 0);

    // Small instance: decode at 200, async reset mid-run, then a full run.
    reset_b = 1'b0;
    @(negedge clock);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    begin
      int n;
      n = 0;
      while (int'(count_b) != 200 && n < 1000) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (n >= 1000) begin
        failures++;
        $display("FAIL b_wait200 timeout, actual count=%0d", count_b);
      end
    end
    check("b_addr_r@200", addr_r_b, 6'd8);
    check("b_addr_s1@200", addr_s1_b, 8'd64);
    check("b_addr_s2@200", addr_s2_b, 8'd56);
    check("b_vector_x@200", vector_x_b, 3'd4);
    check("b_vector_y@200", vector_y_b, 3'd6);
    check("b_s1s2_mux@200", s1s2_mux_b, 8'h01);
    check("b_comp_start@200", comp_start_b, 1);
    reset_b = 1'b1;
    #1;
    check("b_async_rst_count", count_b, 0);
    check("b_async_rst_busy", busy_b, 0);
    check("b_async_rst_done", done_b, 0);
    @(negedge clock);
    reset_b = 1'b0;
    sb_busy = busy_tot_b; sb_done = done_tot_b; sb_pe = pe_tot_b;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    begin
      int n;
      n = 0;
      while (!done_b && n < 1000) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (n >= 1000) begin
        failures++;
        $display("FAIL b_done timeout, actual busy=%0d", busy_b);
      end
    end
    check("b_count_at_done", count_b, 519);
    check("b_busy_at_done", busy_b, 0);
    @(negedge clock);
    check("b_busy_cycles", busy_tot_b - sb_busy, 520);
    check("b_done_pulses", done_tot_b - sb_done, 1);
    check("b_pe_pulses", pe_tot_b - sb_pe, 64);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
